// File: rtl/ppu_ri_bridge.sv
// ppu_ri_bridge
//   CPU-side initiator for the PPU register interface. CPU bus cycles at $2000-$3FFF become one
//   ri_en_out strobe with sel/wr/data held stable around it, and read data is returned to the CPU.
//   A CPU write to $4014 runs a sprite DMA: 256 OAMDATA writes (sel 4), each byte fetched from
//   {page, count}. The CPU is stalled through cpu_rdy_out whenever the bridge is not idle.
// Ports
//   clk_in, rst_in                 clock, synchronous active-high reset
//   cpu_cyc_in/a/r_nw/d_in         CPU bus cycle strobe, address, direction, write data
//   cpu_d_out, cpu_dval_out        read data to CPU, one-cycle update pulse
//   cpu_rdy_out                    1 only when idle
//   ri_en/sel/wr/data_out          PPU register strobe, select, direction (1 = read), write data
//   ri_data_in                     PPU read data, sampled at the end of the read wait
//   dma_addr_out, dma_rd_out       DMA memory address and read strobe
//   dma_data_in                    DMA memory data, valid the cycle after dma_rd_out
module ppu_ri_bridge #(
    parameter int unsigned RI_PULSE_W = 2,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_cyc_in,
    input  logic [15:0] cpu_a_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  cpu_d_in,
    output logic [7:0]  cpu_d_out,
    output logic        cpu_dval_out,
    output logic        cpu_rdy_out,
    output logic        ri_en_out,
    output logic [2:0]  ri_sel_out,
    output logic        ri_wr_out,
    output logic [7:0]  ri_data_out,
    input  logic [7:0]  ri_data_in,
    output logic [15:0] dma_addr_out,
    output logic        dma_rd_out,
    input  logic [7:0]  dma_data_in
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRdWait,
        StDmaRd,
        StDmaCap
    } state_e;

    localparam logic [7:0] PulseLast = 8'(RI_PULSE_W - 1);
    localparam logic [7:0] RdLast    = 8'(RD_LAT - 1);

    state_e     state_q;
    logic [7:0] cnt_q;    // cycles spent in STROBE / RDWAIT
    logic       dma_q;    // current access belongs to a DMA
    logic [7:0] page_q;
    logic [7:0] count_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            cnt_q        <= 8'h00;
            dma_q        <= 1'b0;
            page_q       <= 8'h00;
            count_q      <= 8'h00;
            cpu_d_out    <= 8'h00;
            cpu_dval_out <= 1'b0;
            cpu_rdy_out  <= 1'b1;
            ri_en_out    <= 1'b0;
            ri_sel_out   <= 3'h0;
            ri_wr_out    <= 1'b1;
            ri_data_out  <= 8'h00;
            dma_addr_out <= 16'h0000;
            dma_rd_out   <= 1'b0;
        end else begin
            cpu_dval_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_cyc_in) begin
                        if (cpu_a_in[15:13] == 3'b001) begin
                            ri_sel_out  <= cpu_a_in[2:0];
                            ri_wr_out   <= cpu_r_nw_in;
                            ri_data_out <= cpu_d_in;
                            dma_q       <= 1'b0;
                            cpu_rdy_out <= 1'b0;
                            state_q     <= StSetup;
                        end else if (cpu_a_in == 16'h4014 && !cpu_r_nw_in) begin
                            page_q       <= cpu_d_in;
                            count_q      <= 8'h00;
                            dma_q        <= 1'b1;
                            dma_rd_out   <= 1'b1;
                            dma_addr_out <= {cpu_d_in, 8'h00};
                            cpu_rdy_out  <= 1'b0;
                            state_q      <= StDmaRd;
                        end
                    end
                end
                StSetup: begin
                    ri_en_out <= 1'b1;
                    cnt_q     <= 8'h00;
                    state_q   <= StStrobe;
                end
                StStrobe: begin
                    if (cnt_q == PulseLast) begin
                        ri_en_out <= 1'b0;
                        state_q   <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 8'h01;
                    end
                end
                StHold: begin
                    if (dma_q) begin
                        // 8-bit count wraps to 0 after the last byte; page never advances
                        count_q <= count_q + 8'h01;
                        if (count_q == 8'hFF) begin
                            dma_q       <= 1'b0;
                            cpu_rdy_out <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            dma_rd_out   <= 1'b1;
                            dma_addr_out <= {page_q, count_q + 8'h01};
                            state_q      <= StDmaRd;
                        end
                    end else if (!ri_wr_out) begin
                        cpu_rdy_out <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        cnt_q   <= 8'h00;
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (cnt_q == RdLast) begin
                        cpu_d_out    <= ri_data_in;
                        cpu_dval_out <= 1'b1;
                        cpu_rdy_out  <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'h01;
                    end
                end
                StDmaRd: begin
                    dma_rd_out <= 1'b0;
                    state_q    <= StDmaCap;
                end
                StDmaCap: begin
                    ri_data_out <= dma_data_in;
                    ri_sel_out  <= 3'h4;
                    ri_wr_out   <= 1'b0;
                    state_q     <= StSetup;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_ri_bridge.sv
// Directed bench for ppu_ri_bridge: register writes/reads, mirror decode, sprite DMA,
// reset aborts and ignored addresses.
module tb_ppu_ri_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_cyc = 1'b0;
    logic [15:0] cpu_a = 16'h0000;
    logic        cpu_r_nw = 1'b1;
    logic [7:0]  cpu_d = 8'h00;
    logic [7:0]  cpu_d_out;
    logic        cpu_dval_out;
    logic        cpu_rdy_out;
    logic        ri_en_out;
    logic [2:0]  ri_sel_out;
    logic        ri_wr_out;
    logic [7:0]  ri_data_out;
    logic [7:0]  ri_data_in = 8'h00;
    logic [15:0] dma_addr_out;
    logic        dma_rd_out;
    logic [7:0]  dma_data_in = 8'h00;

    always #5 clk = ~clk;

    ppu_ri_bridge #(.RI_PULSE_W(2), .RD_LAT(2)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .cpu_cyc_in   (cpu_cyc),
        .cpu_a_in     (cpu_a),
        .cpu_r_nw_in  (cpu_r_nw),
        .cpu_d_in     (cpu_d),
        .cpu_d_out    (cpu_d_out),
        .cpu_dval_out (cpu_dval_out),
        .cpu_rdy_out  (cpu_rdy_out),
        .ri_en_out    (ri_en_out),
        .ri_sel_out   (ri_sel_out),
        .ri_wr_out    (ri_wr_out),
        .ri_data_out  (ri_data_out),
        .ri_data_in   (ri_data_in),
        .dma_addr_out (dma_addr_out),
        .dma_rd_out   (dma_rd_out),
        .dma_data_in  (dma_data_in)
    );

    // CPU memory: mem[addr] = addr[7:0] ^ 0xA5, data one cycle after the read strobe
    always @(posedge clk) begin
        if (dma_rd_out) dma_data_in <= dma_addr_out[7:0] ^ 8'hA5;
    end

    // Strobe / DMA-read / dval monitor
    int          en_rises = 0;
    int          en_high = 0;
    int          dma_reads = 0;
    int          dval_cnt = 0;
    logic        en_prev = 1'b0;
    logic [7:0]  rise_data [0:2047];
    logic [2:0]  rise_sel [0:2047];
    logic        rise_wr [0:2047];
    logic [15:0] rd_addr [0:2047];

    always @(negedge clk) begin
        if (ri_en_out) en_high++;
        if (ri_en_out && !en_prev) begin
            if (en_rises < 2048) begin
                rise_data[en_rises] = ri_data_out;
                rise_sel[en_rises]  = ri_sel_out;
                rise_wr[en_rises]   = ri_wr_out;
            end
            en_rises++;
        end
        en_prev = ri_en_out;
        if (dma_rd_out) begin
            if (dma_reads < 2048) rd_addr[dma_reads] = dma_addr_out;
            dma_reads++;
        end
        if (cpu_dval_out) dval_cnt++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [15:0] a, input logic rnw, input logic [7:0] d);
        @(posedge clk); #1;
        cpu_cyc = 1'b1; cpu_a = a; cpu_r_nw = rnw; cpu_d = d;
        @(posedge clk); #1;
        cpu_cyc = 1'b0;
    endtask

    // Results of watch(): first-sample snapshot, stall length, dval position
    int         w_low;
    int         w_dval_at;
    logic [7:0] w_dval_d;
    logic       w_done;
    logic [2:0] s_sel;
    logic       s_wr;
    logic [7:0] s_data;
    logic       s_en;

    task automatic watch(input string tag, input int budget);
        w_low = 0; w_dval_at = -1; w_dval_d = 8'h00; w_done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (k == 0) begin
                s_sel = ri_sel_out; s_wr = ri_wr_out; s_data = ri_data_out; s_en = ri_en_out;
            end
            if (cpu_dval_out && w_dval_at < 0) begin
                w_dval_at = k; w_dval_d = cpu_d_out;
            end
            if (cpu_rdy_out) begin
                w_done = 1'b1;
                break;
            end
            w_low++;
        end
        check({tag, "_rdy_return"}, 32'(w_done), 32'd1);
        #2;
    endtask

    int r0, h0, d0, v0, bad, stall;

    initial begin
        // Reset values, sampled while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en", 32'(ri_en_out), 32'd0);
        check("rst_sel", 32'(ri_sel_out), 32'd0);
        check("rst_wr", 32'(ri_wr_out), 32'd1);
        check("rst_data", 32'(ri_data_out), 32'd0);
        check("rst_cpu_d", 32'(cpu_d_out), 32'd0);
        check("rst_dval", 32'(cpu_dval_out), 32'd0);
        check("rst_rdy", 32'(cpu_rdy_out), 32'd1);
        check("rst_dma_rd", 32'(dma_rd_out), 32'd0);
        check("rst_dma_addr", 32'(dma_addr_out), 32'd0);
        rst = 1'b0;

        // T1: write $2000 = 0x90
        r0 = en_rises; h0 = en_high; d0 = dval_cnt;
        access(16'h2000, 1'b0, 8'h90);
        watch("t1", 20);
        check("t1_setup_sel", 32'(s_sel), 32'd0);
        check("t1_setup_wr", 32'(s_wr), 32'd0);
        check("t1_setup_data", 32'(s_data), 32'h90);
        check("t1_setup_en", 32'(s_en), 32'd0);
        check("t1_stall", 32'(w_low), 32'd4);
        check("t1_en_high", 32'(en_high - h0), 32'd2);
        check("t1_en_rises", 32'(en_rises - r0), 32'd1);
        check("t1_no_dval", 32'(dval_cnt - d0), 32'd0);

        // T2: read $2002, PPU returns 0x80
        ri_data_in = 8'h80;
        r0 = en_rises;
        access(16'h2002, 1'b1, 8'h00);
        watch("t2", 20);
        check("t2_sel", 32'(s_sel), 32'd2);
        check("t2_wr", 32'(s_wr), 32'd1);
        check("t2_stall", 32'(w_low), 32'd6);
        check("t2_dval_at", 32'(w_dval_at), 32'd6);
        check("t2_cpu_d", 32'(w_dval_d), 32'h80);
        check("t2_en_rises", 32'(en_rises - r0), 32'd1);
        ri_data_in = 8'h3C;

        // T3: write $3FFF = 0x5A (mirror of $2007)
        r0 = en_rises;
        access(16'h3FFF, 1'b0, 8'h5A);
        watch("t3", 20);
        check("t3_en_rises", 32'(en_rises - r0), 32'd1);
        check("t3_sel", 32'(rise_sel[r0]), 32'd7);
        check("t3_data", 32'(rise_data[r0]), 32'h5A);
        check("t3_wr", 32'(rise_wr[r0]), 32'd0);
        check("t3_stall", 32'(w_low), 32'd4);

        // T4: sprite DMA from page $02
        r0 = en_rises; v0 = dma_reads; d0 = dval_cnt;
        access(16'h4014, 1'b0, 8'h02);
        watch("t4", 2000);
        check("t4_stall", 32'(w_low), 32'd1536);
        check("t4_en_rises", 32'(en_rises - r0), 32'd256);
        check("t4_dma_reads", 32'(dma_reads - v0), 32'd256);
        check("t4_no_dval", 32'(dval_cnt - d0), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (rise_sel[r0 + i] !== 3'h4 || rise_wr[r0 + i] !== 1'b0 ||
                rise_data[r0 + i] !== (8'(i) ^ 8'hA5))
                bad++;
            if (rd_addr[v0 + i] !== (16'h0200 + 16'(i))) bad++;
        end
        check("t4_sequence_errors", 32'(bad), 32'd0);

        // T5a: reset while the strobe is high
        access(16'h2001, 1'b0, 8'h11);
        @(negedge clk);
        @(negedge clk);
        check("t5_in_strobe", 32'(ri_en_out), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_strobe_abort_en", 32'(ri_en_out), 32'd0);
        check("t5_strobe_abort_rdy", 32'(cpu_rdy_out), 32'd1);
        rst = 1'b0;

        // T5b: reset at DMA byte 100, then restart
        r0 = en_rises;
        access(16'h4014, 1'b0, 8'h03);
        for (int k = 0; k < 2000 && en_rises < r0 + 101; k++) begin
            @(negedge clk); #1;
        end
        check("t5_reached_byte_100", 32'(en_rises - r0), 32'd101);
        rst = 1'b1;
        @(negedge clk);
        check("t5_dma_abort_en", 32'(ri_en_out), 32'd0);
        check("t5_dma_abort_rdy", 32'(cpu_rdy_out), 32'd1);
        check("t5_dma_abort_rd", 32'(dma_rd_out), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t5_no_resume", 32'(en_rises - r0), 32'd101);
        r0 = en_rises; v0 = dma_reads;
        access(16'h4014, 1'b0, 8'h02);
        watch("t5", 2000);
        stall = w_low;
        check("t5_restart_stall", 32'(stall), 32'd1536);
        check("t5_restart_first", 32'(rd_addr[v0]), 32'h0200);
        check("t5_restart_last", 32'(rd_addr[v0 + 255]), 32'h02FF);
        check("t5_restart_data0", 32'(rise_data[r0]), 32'hA5);

        // T6: ignored addresses
        r0 = en_rises; d0 = dval_cnt; bad = 0;
        access(16'h4000, 1'b0, 8'h77);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!cpu_rdy_out) bad++;
        end
        access(16'h4014, 1'b1, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!cpu_rdy_out) bad++;
        end
        #2;
        check("t6_rdy_low_cycles", 32'(bad), 32'd0);
        check("t6_en_rises", 32'(en_rises - r0), 32'd0);
        check("t6_dval", 32'(dval_cnt - d0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
